// File: rtl/or_nway_pipe_if.sv
// rtl/or_nway_pipe_if.sv - stream and result bundle for the pipelined N-way OR reduction
//
// Purpose:
//   Groups the word-input side, the sticky clear and the result side of
//   or_nway_pipe so the block and its driver share one connection.
//
// Signals:
//   in_valid  producer -> reducer  1      : in carries a word this cycle
//   in        producer -> reducer  WIDTH  : word to reduce
//   clear     producer -> reducer  1      : synchronous clear of the sticky accumulator
//   out_valid reducer -> producer  1      : out / out_idx carry a result
//   out       reducer -> producer  1      : OR of all bits of the matching word
//   out_idx   reducer -> producer  IDX_W  : lowest set bit index (0 when out = 0)
//   sticky    reducer -> producer  1      : OR of all valid results since clear/reset
//
// Modports:
//   master : the side that supplies words and consumes results
//   slave  : the reduction pipeline itself
interface or_nway_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic             clear;
  logic             out_valid;
  logic             out;
  logic [IDX_W-1:0] out_idx;
  logic             sticky;

  modport master (
    output in_valid,
    output in,
    output clear,
    input  out_valid,
    input  out,
    input  out_idx,
    input  sticky
  );

  modport slave (
    input  in_valid,
    input  in,
    input  clear,
    output out_valid,
    output out,
    output out_idx,
    output sticky
  );
endinterface

// File: rtl/or_nway_pipe.sv
// rtl/or_nway_pipe.sv - pipelined N-way OR reduction with lowest-set-bit index and sticky flag
//
// Purpose:
//   Reduces a WIDTH-bit word to one "any bit set" flag through a balanced
//   binary tree of 2-input OR nodes, one register level per tree level, so
//   the latency is LEVELS = clog2(WIDTH) cycles and a new word may enter
//   every cycle. Each node also carries the index of its lowest set leaf.
//   A sticky bit accumulates every valid result until cleared.
//
// Ports:
//   clk    in  1          : rising-edge clock for all state
//   rst_n  in  1          : asynchronous active-low reset
//   bus    slave modport  : in_valid / in / clear in, out_valid / out / out_idx / sticky out
//
// Storage layout:
//   All tree levels live in one flat node array. Level l holds nodes_at(l)
//   nodes starting at node_offset(l); the last level is a single root node.
module or_nway_pipe #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  or_nway_pipe_if.slave bus
);

  // Output node count of tree level l; level -1 is the leaf row itself.
  function automatic int nodes_at(input int l);
    int n;
    n = WIDTH;
    for (int i = 0; i <= l; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  // First flat-array slot of tree level l.
  function automatic int node_offset(input int l);
    int s;
    s = 0;
    for (int k = 0; k < l; k++) begin
      s = s + nodes_at(k);
    end
    return s;
  endfunction

  localparam int IDX_W  = $clog2(WIDTH);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int TOT    = node_offset(LEVELS);
  localparam int ROOT   = TOT - 1;

  logic [TOT-1:0]    any_q;
  logic [TOT-1:0]    any_d;
  logic [IDX_W-1:0]  idx_q [TOT];
  logic [IDX_W-1:0]  idx_d [TOT];
  logic [TOT-1:0]    ld;
  logic [LEVELS-1:0] vld_q;
  logic              sticky_q;
  logic              sticky_d;
  logic              res_any;

  // Combinational next-state of every node, plus the per-node load enable
  // taken from the valid bit that feeds that node's level.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NIN  = nodes_at(l - 1);
    localparam int NOUT = nodes_at(l);
    localparam int OIN  = node_offset(l - 1);
    localparam int OOUT = node_offset(l);

    logic lvl_vin;

    if (l == 0) begin : g_vin_src
      assign lvl_vin = bus.in_valid;
    end else begin : g_vin_pipe
      assign lvl_vin = vld_q[l-1];
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_node
      logic             l_any;
      logic             r_any;
      logic [IDX_W-1:0] l_idx;
      logic [IDX_W-1:0] r_idx;

      if (l == 0) begin : g_leaf
        assign l_any = bus.in[2*j];
        assign l_idx = IDX_W'(2 * j);
        if (2 * j + 1 < NIN) begin : g_pair
          assign r_any = bus.in[2*j+1];
          assign r_idx = IDX_W'(2 * j + 1);
        end else begin : g_odd
          // Odd node count: the last node pairs with an all-zero node.
          assign r_any = 1'b0;
          assign r_idx = '0;
        end
      end else begin : g_inner
        assign l_any = any_q[OIN+2*j];
        assign l_idx = idx_q[OIN+2*j];
        if (2 * j + 1 < NIN) begin : g_pair
          assign r_any = any_q[OIN+2*j+1];
          assign r_idx = idx_q[OIN+2*j+1];
        end else begin : g_odd
          assign r_any = 1'b0;
          assign r_idx = '0;
        end
      end

      // Lower-index child wins, so the root ends up with the lowest set bit.
      assign any_d[OOUT+j] = l_any | r_any;
      assign idx_d[OOUT+j] = l_any ? l_idx : (r_any ? r_idx : '0);
      assign ld[OOUT+j]    = lvl_vin;
    end
  end

  // Valid shifts every cycle; data nodes load only behind a valid word so
  // bubbles leave the previous contents untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      any_q <= '0;
      for (int k = 0; k < TOT; k++) begin
        idx_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= bus.in_valid;
      for (int l = 1; l < LEVELS; l++) begin
        vld_q[l] <= vld_q[l-1];
      end
      for (int k = 0; k < TOT; k++) begin
        if (ld[k]) begin
          any_q[k] <= any_d[k];
          idx_q[k] <= idx_d[k];
        end
      end
    end
  end

  assign res_any = vld_q[LEVELS-1] & any_q[ROOT];

  // Clear is applied before the OR-in, so a result emerging in the same
  // cycle as clear still sets the accumulator.
  assign sticky_d = (bus.clear ? 1'b0 : sticky_q) | res_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  // Root register gated by its valid bit; stale data never leaks out.
  assign bus.out_valid = vld_q[LEVELS-1];
  assign bus.out       = res_any;
  assign bus.out_idx   = vld_q[LEVELS-1] ? idx_q[ROOT] : '0;
  assign bus.sticky    = sticky_q;

endmodule
